// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: decode/FPU-side handshake and status bundle for the FP issue controller
interface fpu_issue_ctrl_if #(parameter int CNT_W = 16);
  logic id_valid, id_fp, id_regwrite;
  logic [4:0] id_rs, id_rt, id_rd;
  logic fpu_valid;
  logic fpu_start, stall, busy, wb_fp, timeout;
  logic [4:0] pend_rd;
  logic [CNT_W-1:0] fp_count;
  modport master(
    output id_valid, id_fp, id_regwrite, id_rs, id_rt, id_rd, fpu_valid,
    input fpu_start, stall, busy, wb_fp, timeout, pend_rd, fp_count
  );
  modport slave(
    input id_valid, id_fp, id_regwrite, id_rs, id_rt, id_rd, fpu_valid,
    output fpu_start, stall, busy, wb_fp, timeout, pend_rd, fp_count
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: multi-cycle FPU sequencer with stall, RAW scoreboard and watchdog
module fpu_issue_ctrl #(
  parameter int WD_W  = 6,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic reset,
  fpu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, POST} state_t;
  state_t state, state_nx;
  logic [4:0] pend_rd;
  logic pend_we, start_q, wb_q, to_q;
  logic [WD_W-1:0] wd, wd_inc;
  logic [CNT_W-1:0] cnt;
  logic hazard, accept, done, expire;
  assign hazard = state == POST && pend_we && pend_rd != 5'd0 &&
                  (bus.id_rs == pend_rd || bus.id_rt == pend_rd);
  assign accept = bus.id_valid && bus.id_fp && !hazard && state != RUN;
  // fpu_valid coincident with the start pulse belongs to nothing we launched
  assign done   = state == RUN && bus.fpu_valid && !start_q;
  assign wd_inc = wd + 1'b1;
  assign expire = state == RUN && !done && &wd_inc;
  always_comb begin
    state_nx = IDLE;
    if (accept) state_nx = RUN;
    else if (state == RUN) state_nx = done ? POST : expire ? IDLE : RUN;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      wb_q    <= 1'b0;
      to_q    <= 1'b0;
      pend_rd <= 5'd0;
      pend_we <= 1'b0;
      wd      <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      start_q <= accept;
      wb_q    <= done;
      if (done) cnt <= cnt + 1'b1;
      if (expire) to_q <= 1'b1;
      if (accept) begin
        pend_rd <= bus.id_rd;
        pend_we <= bus.id_regwrite;
        wd      <= '0;
      end else if (state == POST || expire) begin
        pend_rd <= 5'd0;
        pend_we <= 1'b0;
      end else if (state == RUN && !done) begin
        wd <= wd_inc;
      end
    end
  end
  assign bus.fpu_start = start_q;
  assign bus.wb_fp     = wb_q;
  assign bus.timeout   = to_q;
  assign bus.pend_rd   = pend_rd;
  assign bus.fp_count  = cnt;
  assign bus.busy      = state != IDLE;
  assign bus.stall     = state == RUN || (bus.id_valid && hazard);
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: cycle-by-cycle vector table plus a counter-wrap sequence
module tb_fpu_issue_ctrl;
  logic CLK = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  always #5 CLK = ~CLK;
  fpu_issue_ctrl_if #(.CNT_W(4)) bus();
  fpu_issue_ctrl #(.WD_W(3), .CNT_W(4)) dut(.CLK(CLK), .reset(reset), .bus(bus.slave));
  typedef struct {
    logic rst, iv, fp, rw;
    logic [4:0] rs, rt, rd;
    logic fv;
    logic st, sl, bz, wb;
    logic [4:0] prd;
    logic [3:0] cnt;
    logic to;
  } row_t;
  row_t tbl[$];
  function automatic row_t mk(input logic rst, iv, fp, rw, input logic [4:0] rs, rt, rd,
                              input logic fv, st, sl, bz, wb, input logic [4:0] prd,
                              input logic [3:0] cnt, input logic to);
    row_t r;
    r.rst = rst; r.iv = iv; r.fp = fp; r.rw = rw; r.rs = rs; r.rt = rt; r.rd = rd; r.fv = fv;
    r.st = st; r.sl = sl; r.bz = bz; r.wb = wb; r.prd = prd; r.cnt = cnt; r.to = to;
    return r;
  endfunction
  task automatic chk(input string n, input int idx, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL row%0d %s got=%0h want=%0h", idx, n, a, e);
    end
  endtask
  task automatic apply(input row_t r, input int idx);
    @(posedge CLK);
    #1;
    reset = r.rst;
    bus.id_valid = r.iv; bus.id_fp = r.fp; bus.id_regwrite = r.rw;
    bus.id_rs = r.rs; bus.id_rt = r.rt; bus.id_rd = r.rd; bus.fpu_valid = r.fv;
    @(negedge CLK);
    chk("fpu_start", idx, 16'(bus.fpu_start), 16'(r.st));
    chk("stall",     idx, 16'(bus.stall),     16'(r.sl));
    chk("busy",      idx, 16'(bus.busy),      16'(r.bz));
    chk("wb_fp",     idx, 16'(bus.wb_fp),     16'(r.wb));
    chk("pend_rd",   idx, 16'(bus.pend_rd),   16'(r.prd));
    chk("fp_count",  idx, 16'(bus.fp_count),  16'(r.cnt));
    chk("timeout",   idx, 16'(bus.timeout),   16'(r.to));
  endtask
  initial begin
    reset = 1'b1;
    bus.id_valid = 0; bus.id_fp = 0; bus.id_regwrite = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.fpu_valid = 0;
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // single op rd=5, FPU answers 4 cycles after start
    tbl.push_back(mk(0,1,1,1,1,2,5,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,1,1,0,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,1,1,0,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,1,1,0,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,1,5,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    // rd=7 then rs=7 in POST: one stall cycle, accepted from IDLE
    tbl.push_back(mk(0,1,1,1,1,2,7,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,1,1,0,7,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,7,1,0));
    tbl.push_back(mk(0,1,1,1,7,3,9,0, 0,1,1,1,7,2,0));
    tbl.push_back(mk(0,1,1,1,7,3,9,0, 0,0,0,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,9,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,9,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,1,9,3,0));
    // rd=0 never hazards; back-to-back launch from POST
    tbl.push_back(mk(0,1,1,1,0,0,0,0, 0,0,0,0,0,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,0,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,0,3,0));
    tbl.push_back(mk(0,1,1,1,0,0,4,0, 0,0,1,1,0,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,4,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,4,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,1,4,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,5,0));
    // non-writing op: no hazard on its rd
    tbl.push_back(mk(0,1,1,0,0,0,6,0, 0,0,0,0,0,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,6,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,6,5,0));
    tbl.push_back(mk(0,1,0,1,6,6,1,0, 0,0,1,1,6,6,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,6,0));
    // integer op reading rt=pend_rd in POST stalls too
    tbl.push_back(mk(0,1,1,1,0,0,8,0, 0,0,0,0,0,6,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,8,6,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,8,6,0));
    tbl.push_back(mk(0,1,0,1,0,8,1,0, 0,1,1,1,8,7,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,7,0));
    // hung FPU: 7 RUN cycles then timeout
    tbl.push_back(mk(0,1,1,1,0,0,3,0, 0,0,0,0,0,7,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,3,7,0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,1,1,0,3,7,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,7,1));
    // still accepts after timeout
    tbl.push_back(mk(0,1,1,1,0,0,2,0, 0,0,0,0,0,7,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,2,7,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,1,1,0,2,7,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,1,2,8,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,8,1));
    // reset two cycles into RUN, then stray fpu_valid
    tbl.push_back(mk(0,1,1,1,0,0,11,0, 0,0,0,0,0,8,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,11,8,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,0,11,8,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    repeat (2) @(posedge CLK);
    foreach (tbl[i]) apply(tbl[i], i);
    // 16 ops wrap the 4-bit counter back to zero
    for (int k = 0; k < 16; k++) begin
      apply(mk(0,1,1,1,0,0,1,0, 0,0,0,0,0,4'(k),0), 1000 + 4*k);
      apply(mk(0,0,0,0,0,0,0,0, 1,1,1,0,1,4'(k),0), 1001 + 4*k);
      apply(mk(0,0,0,0,0,0,0,1, 0,1,1,0,1,4'(k),0), 1002 + 4*k);
      apply(mk(0,0,0,0,0,0,0,0, 0,0,1,1,1,4'(k+1),0), 1003 + 4*k);
    end
    apply(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0), 2000);
    apply(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0), 2001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
